// File: rtl/cnn_frame_sequencer_pkg.sv
// cnn_seq_pkg: shared state encoding and default geometry for the CNN frame sequencer
package cnn_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  localparam int DEF_WIDTH = 480;
  localparam int DEF_HEIGHT = 272;
  localparam int DEF_DEPTH = DEF_WIDTH * DEF_HEIGHT;
  localparam int DEF_CNT_W = 17;
endpackage

// File: rtl/cnn_frame_sequencer_if.sv
// cnn_frame_sequencer_if: control/config bus between host-side logic (master) and the sequencer (slave)
//   i* signals: clock enable, start/abort/continuous requests, live config words, conv result valid
//   o* signals: window enable, shadow config, busy/done/error status, pixel and frame counters
interface cnn_frame_sequencer_if import cnn_seq_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
);
  logic iEnClk, iStart, iAbort, iCont, iResValid;
  logic [31:0] iReg0, iReg1, iReg2, iReg3;
  logic oWinEn, oBusy, oDone, oErr;
  logic [31:0] oReg0, oReg1, oReg2, oReg3;
  logic [CNT_W-1:0] oPixCnt;
  logic [15:0] oFrameCnt;
  modport master (
    output iEnClk, iStart, iAbort, iCont, iResValid, iReg0, iReg1, iReg2, iReg3,
    input oWinEn, oBusy, oDone, oErr, oReg0, oReg1, oReg2, oReg3, oPixCnt, oFrameCnt
  );
  modport slave (
    input iEnClk, iStart, iAbort, iCont, iResValid, iReg0, iReg1, iReg2, iReg3,
    output oWinEn, oBusy, oDone, oErr, oReg0, oReg1, oReg2, oReg3, oPixCnt, oFrameCnt
  );
endinterface

// File: rtl/cnn_cfg_shadow.sv
// cnn_cfg_shadow: 4x32 shadow register bank loaded by a single strobe
//   iClk/iRsn clock and async active-low reset; iLoad strobe; iD live words; oQ shadow words
module cnn_cfg_shadow (
  input  logic iClk,
  input  logic iRsn,
  input  logic iLoad,
  input  logic [3:0][31:0] iD,
  output logic [3:0][31:0] oQ
);
  always_ff @(posedge iClk or negedge iRsn)
    if (!iRsn) oQ <= '0;
    else if (iLoad) oQ <= iD;
endmodule

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: frame-level controller for the CNN datapath
//   iClk/iRsn clock and async active-low reset; bus (slave modport) carries requests,
//   live config, conv result valid, window enable, shadow config and status counters.
//   Optional stall timeout compiled in with macro CNN_SEQ_TIMEOUT_EN.
module cnn_frame_sequencer import cnn_seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int DEPTH = WIDTH * HEIGHT,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DRAIN_CYC = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic iClk,
  input logic iRsn,
  cnn_frame_sequencer_if.slave bus
);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  state_t state, nextState;
  logic [CNT_W-1:0] pixCnt;
  logic [DW-1:0] drainCnt;
  logic [15:0] frameCnt;
  logic [3:0][31:0] shadowQ;
  logic contQ, busy, done, load, enterDone, pixInc, lastPix, lastDrain, timeout;
  always_comb begin
    pixInc = state == RUN && bus.iEnClk && bus.iResValid && !bus.iAbort;
    lastPix = pixInc && pixCnt == CNT_W'(DEPTH - 1);
    lastDrain = state == DRAIN && bus.iEnClk && drainCnt == DW'(DRAIN_CYC - 1);
    nextState = state;
    if (bus.iAbort || timeout) nextState = IDLE;
    else
      case (state)
        IDLE: nextState = bus.iStart ? LOAD : IDLE;
        LOAD: nextState = bus.iEnClk ? RUN : LOAD;
        RUN: nextState = lastPix ? DRAIN : RUN;
        DRAIN: nextState = lastDrain ? DONE : DRAIN;
        DONE: nextState = !bus.iEnClk ? DONE : contQ ? LOAD : IDLE;
        default: nextState = IDLE;
      endcase
    load = nextState == LOAD && state != LOAD;
    enterDone = nextState == DONE && state != DONE;
  end
  always_ff @(posedge iClk or negedge iRsn)
    if (!iRsn) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      contQ <= 1'b0;
      pixCnt <= '0;
      drainCnt <= '0;
      frameCnt <= '0;
    end else begin
      state <= nextState;
      busy <= nextState != IDLE;
      done <= enterDone;
      contQ <= enterDone ? bus.iCont : contQ;
      pixCnt <= load ? '0 : pixCnt + CNT_W'(pixInc);
      drainCnt <= state != DRAIN ? '0 : drainCnt + DW'(bus.iEnClk);
      frameCnt <= frameCnt + 16'(enterDone);
    end
`ifdef CNN_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] stallCnt;
  logic err;
  // Abort takes precedence, so a coincident stall expiry must not raise the flag.
  assign timeout = state == RUN && bus.iEnClk && !bus.iResValid && !bus.iAbort
                   && stallCnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge iClk or negedge iRsn)
    if (!iRsn) begin
      stallCnt <= '0;
      err <= 1'b0;
    end else begin
      stallCnt <= (state != RUN || (bus.iEnClk && bus.iResValid)) ? '0 : stallCnt + TW'(bus.iEnClk);
      err <= (state == IDLE && load) ? 1'b0 : err | timeout;
    end
  assign bus.oErr = err;
`else
  assign timeout = 1'b0;
  assign bus.oErr = 1'b0;
`endif
  cnn_cfg_shadow uShadow (
    .iClk(iClk),
    .iRsn(iRsn),
    .iLoad(load),
    .iD({bus.iReg3, bus.iReg2, bus.iReg1, bus.iReg0}),
    .oQ(shadowQ)
  );
  assign bus.oReg0 = shadowQ[0];
  assign bus.oReg1 = shadowQ[1];
  assign bus.oReg2 = shadowQ[2];
  assign bus.oReg3 = shadowQ[3];
  assign bus.oWinEn = state == RUN;
  assign bus.oBusy = busy;
  assign bus.oDone = done;
  assign bus.oPixCnt = pixCnt;
  assign bus.oFrameCnt = frameCnt;
endmodule

// File: doc/cnn_frame_sequencer.md
Name: cnn_frame_sequencer

Overview:
Frame-level controller for the CNN datapath (window generator → 3x3 conv → RGB565 packer → output buffer).
- Latches AXI-lite kernel/config registers into shadow registers at frame start, so the conv engine never sees mid-frame changes.
- Gates the window generator enable.
- Counts conv result pulses to detect frame completion, flushes the pipeline, then signals done.
- Supports single-shot and continuous modes.

Parameters:
- WIDTH, 480, image width in pixels.
- HEIGHT, 272, image height in pixels.
- DEPTH, WIDTH*HEIGHT, result pulses per frame (130560).
- CNT_W, 17, pixel counter width; must satisfy 2^CNT_W > DEPTH.
- DRAIN_CYC, 8, enabled ticks held in DRAIN for pipeline flush.
- TIMEOUT_CYC, 4096, stall limit in enabled ticks (optional feature only).

Ports:
- iClk  in  1  system clock.
- iRsn  in  1  async active-low reset.
- iEnClk  in  1  clock enable shared with the datapath.
- iStart  in  1  start request pulse (one iClk cycle).
- iAbort  in  1  abort request, level or pulse.
- iCont  in  1  continuous mode; sampled on entry to DONE.
- iReg0..iReg3  in  32 each  live AXI-lite config/kernel words.
- iResValid  in  1  conv result valid (o_result_valid of the conv engine).
- oWinEn  out  1  enable to the window generator.
- oReg0..oReg3  out  32 each  shadow config driven to the conv engine.
- oBusy  out  1  high in every state except IDLE.
- oDone  out  1  one-iClk pulse per completed frame.
- oErr  out  1  sticky timeout flag (0 when the feature is compiled out).
- oPixCnt  out  CNT_W  results counted in the current frame.
- oFrameCnt  out  16  completed frames, wraps at 0xFFFF→0.

Behaviour:
- Reset (iRsn=0, async): state=IDLE; all outputs 0; shadow regs 0; counters 0.
- State advance:
  - LOAD→RUN, the DRAIN counter and DONE→next occur only on iEnClk=1 cycles.
  - IDLE start capture, abort and oDone act on any iClk cycle.
- IDLE:
  - iStart=1 → LOAD; oReg0..3 ← iReg0..3 on that same edge.
  - oPixCnt ← 0.
- LOAD: one enabled tick; oWinEn stays 0 → RUN.
- RUN:
  - oWinEn=1.
  - oPixCnt +1 on each cycle with iEnClk=1 and iResValid=1.
  - The pulse that brings the count to DEPTH → DRAIN; oWinEn drops the next cycle.
- DRAIN:
  - oWinEn=0; further iResValid pulses are ignored (oPixCnt holds at DEPTH).
  - Leaves after DRAIN_CYC enabled ticks → DONE.
- DONE:
  - oDone=1 for exactly one iClk on entry.
  - oFrameCnt +1 on that same cycle.
  - Next enabled tick: iCont=1 → LOAD (shadow regs re-latched from iReg0..3, oPixCnt ← 0); else → IDLE.
- iStart outside IDLE: ignored; no queueing.
- iAbort=1 in any state:
  - Next edge → IDLE; oWinEn=0.
  - No oDone pulse; oFrameCnt unchanged.
  - Shadow regs hold; oPixCnt holds until the next start.
- iAbort and iStart asserted together: abort wins; stay in IDLE.
- Shadow regs change only on the LOAD-entry edge. oReg* is stable for the whole of RUN/DRAIN regardless of iReg* activity.
- oBusy is registered and equals (state != IDLE).

Optional Feature:
- Macro: CNN_SEQ_TIMEOUT_EN.
- When defined:
  - A stall counter runs in RUN, counting enabled ticks since the last iResValid; it resets on each valid.
  - On reaching TIMEOUT_CYC: oErr=1 (sticky), state → IDLE, no oDone.
  - oErr clears only on reset or on the next accepted iStart.
- When undefined: no stall counter; oErr tied to 0; RUN waits indefinitely.

Decomposition:
- Package cnn_seq_pkg holds:
  - state encoding constants IDLE/LOAD/RUN/DRAIN/DONE (3 bits);
  - default WIDTH/HEIGHT/DEPTH;
  - CNT_W.
- One sub-module, cnn_cfg_shadow: 4x32 shadow register bank with a single load strobe, reset to 0.
- FSM and counters stay in the top module.

Test Plan:
- Single frame: iEnClk=1 always, pulse iStart, drive iResValid every cycle → oWinEn high from cycle 2; oDone one pulse after 130560 valids + DRAIN; oFrameCnt=1; oBusy low afterwards.
- Config isolation: iReg0=0x11 at start, change it to 0x22 mid-RUN → oReg0 stays 0x11 until the next LOAD.
- Continuous mode: iCont=1, iReg1 changed between frames → two oDone pulses; oReg1 updates at the second LOAD; oFrameCnt=2.
- Abort mid-RUN at oPixCnt=1000 with iStart asserted in the same cycle → IDLE next cycle, oWinEn=0, no oDone, oFrameCnt=0.
- Clock enable at 1/4 rate, reduced DEPTH=12 → oPixCnt counts only qualified valids; DRAIN lasts 8 enabled ticks (32 iClk).
- With CNN_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16: stop iResValid at count 5 → oErr=1 after 16 enabled ticks, state IDLE; next iStart clears oErr.
